gray_monitor: RTL and testbench
===============================

GRAY_MONITOR -- requirements
Module: gray_monitor

Interface
REQ-001 Parameter WRAP_W, default 8: width of the wrap counter.
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high; clears all state immediately, independent of Clk.
REQ-004 Valid  input  1  sample strobe; Gray is consumed only on cycles where Valid=1.
REQ-005 Gray  input  3  3-bit Gray code from the upstream up-counter.
REQ-006 Clear  input  1  synchronous request to leave FAULT and relock.
REQ-007 Bin  output  3  registered binary equivalent of the last accepted Gray sample.
REQ-008 Locked  output  1  high while in TRACK.
REQ-009 Error  output  1  high while in FAULT (sticky).
REQ-010 WrapCount  output  WRAP_W  registered count of 7->0 wraps; saturates at all-ones.

Function
REQ-011 Gray-to-binary conversion SHALL be b[2]=g[2], b[1]=g[2]^g[1], b[0]=g[2]^g[1]^g[0].
REQ-012 FSM states SHALL be UNLOCK, TRACK and FAULT; the reset state is UNLOCK.
REQ-013 UNLOCK, Valid=1: Bin <= conv(Gray); go to TRACK; WrapCount unchanged.
REQ-014 UNLOCK, Valid=0: hold all outputs.
REQ-015 TRACK, Valid=1, conv(Gray)==Bin: accepted as a hold; no output change.
REQ-016 TRACK, Valid=1, conv(Gray)==Bin+1 mod 8: Bin <= conv(Gray); stay in TRACK.
REQ-017 TRACK, Valid=1, Bin==7 and conv(Gray)==0: treated as a legal step.
  - WrapCount increments by 1.
  - WrapCount holds when already all-ones (no wrap to 0).
REQ-018 TRACK, Valid=1, any other value (backward step, skip, or multi-bit Gray change):
  - go to FAULT.
  - Bin holds its last legal value.
  - WrapCount unchanged.
REQ-019 FAULT: ignore Valid and Gray; hold Bin and WrapCount.
REQ-020 FAULT, Clear=1: go to UNLOCK next edge; WrapCount is retained.
REQ-021 Clear in UNLOCK or TRACK SHALL be ignored.
REQ-022 Latency: Bin, Locked, Error and WrapCount reflect a sample one Clk edge after the Valid cycle.
REQ-023 Outputs SHALL be registered: Locked = (state==TRACK), Error = (state==FAULT), both decoded from the state register.
REQ-024 Valid=0 in any state SHALL change nothing.

Reset
REQ-025 On Reset=1, asynchronously:
  - state=UNLOCK.
  - Bin=3'b000, Locked=0, Error=0, WrapCount=0.
REQ-026 Reset SHALL have priority over Valid and Clear.
REQ-027 Reset asserted mid-TRACK or mid-FAULT SHALL discard the in-flight sample.
REQ-028 After Reset deasserts, the first Valid sample relocks per REQ-013.

Structure
REQ-029 Shared package gray_pkg SHALL hold:
  - state enum {UNLOCK, TRACK, FAULT} and its 2-bit encoding.
  - constant GRAY_W=3.
  - default WRAP_W.
REQ-030 Gray-to-binary conversion SHALL be a separate combinational sub-module, gray2bin (GRAY_W in, GRAY_W out), instantiated once.
REQ-031 All remaining logic SHALL stay in gray_monitor: state register, Bin register, WrapCount register, next-state logic.

Verification
REQ-032 Reset, then Valid with Gray 000,001,011,010,110,111,101,100,000 -> Bin 0..7,0; Locked=1 throughout; Error=0; WrapCount=1.
REQ-033 TRACK at Bin=2 (Gray 011), then Valid with Gray 001 (backward) -> Error=1, Locked=0, Bin=2; further Valid samples ignored; Clear=1 -> UNLOCK, Error=0.
REQ-034 TRACK at Bin=1, then Gray 010 (skip to 3) -> FAULT; repeat Gray 001 instead -> hold, no error.
REQ-035 WRAP_W=2, run 5 full cycles 0..7 -> WrapCount = 3 (saturated, never returns to 0).
REQ-036 Reset asserted asynchronously between edges while in FAULT with WrapCount=4 -> all outputs 0 before the next edge; next Valid Gray 110 -> Bin=4, Locked=1.
REQ-037 Valid=0 for 10 cycles with toggling Gray and Clear -> no output change in any state.

Source files
------------

// File: rtl/gray_pkg.sv
// ---------------------------------------------------------------------------
// gray_pkg
// Shared definitions for the Gray-code monitor slice:
//   state_t        : monitor FSM states with a fixed 2-bit encoding
//   GRAY_W         : width of the Gray code / binary sample
//   WRAP_W_DEFAULT : default width of the wrap counter
// ---------------------------------------------------------------------------
package gray_pkg;

  localparam int GRAY_W         = 3;
  localparam int WRAP_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    UNLOCK = 2'd0,
    TRACK  = 2'd1,
    FAULT  = 2'd2
  } state_t;

endpackage : gray_pkg

// File: rtl/gray2bin.sv
// ---------------------------------------------------------------------------
// gray2bin
// Purely combinational GRAY_W-bit Gray-to-binary converter.
// Ports:
//   Gray : input  [GRAY_W-1:0]  Gray-coded value
//   Bin  : output [GRAY_W-1:0]  binary equivalent
// ---------------------------------------------------------------------------
module gray2bin
  import gray_pkg::*;
(
  input  logic [GRAY_W-1:0] Gray,
  output logic [GRAY_W-1:0] Bin
);

  // Each binary bit is the XOR of all Gray bits at or above its position.
  assign Bin[2] = Gray[2];
  assign Bin[1] = Gray[2] ^ Gray[1];
  assign Bin[0] = Gray[2] ^ Gray[1] ^ Gray[0];

endmodule : gray2bin

// File: rtl/gray_monitor.sv
// ---------------------------------------------------------------------------
// gray_monitor
// Watches a 3-bit Gray code from an upstream up-counter, tracks its binary
// value, flags any illegal transition (sticky until Clear) and counts 7->0
// wraps with a saturating counter.
// Ports:
//   Clk       : input            clock, rising edge
//   Reset     : input            asynchronous, active-high
//   Valid     : input            sample strobe; nothing changes when low
//   Gray      : input  [2:0]     Gray sample
//   Clear     : input            leave FAULT and relock (sampled with Valid)
//   Bin       : output [2:0]     binary value of last accepted sample
//   Locked    : output           high while in TRACK
//   Error     : output           high while in FAULT
//   WrapCount : output [WRAP_W]  saturating count of 7->0 wraps
// ---------------------------------------------------------------------------
module gray_monitor
  import gray_pkg::*;
#(
  parameter int WRAP_W = WRAP_W_DEFAULT
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Valid,
  input  logic [GRAY_W-1:0] Gray,
  input  logic              Clear,
  output logic [GRAY_W-1:0] Bin,
  output logic              Locked,
  output logic              Error,
  output logic [WRAP_W-1:0] WrapCount
);

  state_t            state;
  logic [GRAY_W-1:0] bin_in;

  gray2bin u_gray2bin (
    .Gray (Gray),
    .Bin  (bin_in)
  );

  // Locked/Error are registered alongside the state so they always equal
  // the decode of the state register without a combinational output path.
  // NOTE: every register here uses <= so all updates see pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= UNLOCK;
      Bin       <= '0;
      Locked    <= 1'b0;
      Error     <= 1'b0;
      WrapCount <= '0;
    end else if (Valid) begin
      // Valid=0 freezes everything, including a pending Clear in FAULT.
      unique case (state)
        UNLOCK: begin
          Bin    <= bin_in;
          state  <= TRACK;
          Locked <= 1'b1;
        end
        TRACK: begin
          if (bin_in != Bin) begin
            if (bin_in == Bin + GRAY_W'(1)) begin
              Bin <= bin_in;
              // A legal step out of the top value is a wrap.
              if (Bin == '1 && WrapCount != '1)
                WrapCount <= WrapCount + WRAP_W'(1);
            end else begin
              state  <= FAULT;
              Locked <= 1'b0;
              Error  <= 1'b1;
            end
          end
        end
        FAULT: begin
          if (Clear) begin
            state <= UNLOCK;
            Error <= 1'b0;
          end
        end
        default: begin
          state  <= UNLOCK;
          Locked <= 1'b0;
          Error  <= 1'b0;
        end
      endcase
    end
  end

endmodule : gray_monitor

// File: tb/tb_gray_monitor.sv
module tb_gray_monitor;

  logic       Clk;
  logic       Reset;
  logic       Valid;
  logic [2:0] Gray;
  logic       Clear;

  logic [2:0] bin_a, bin_b;
  logic       locked_a, locked_b, error_a, error_b;
  logic [7:0] wrap_a;
  logic [1:0] wrap_b;

  int errors = 0;
  int checks = 0;

  // Reference model state: plain integers and flags.
  int m_bin;
  bit m_locked;
  bit m_error;
  int m_wraps;

  gray_monitor u_dut (
    .Clk(Clk), .Reset(Reset), .Valid(Valid), .Gray(Gray), .Clear(Clear),
    .Bin(bin_a), .Locked(locked_a), .Error(error_a), .WrapCount(wrap_a)
  );

  gray_monitor #(.WRAP_W(2)) u_dut_w2 (
    .Clk(Clk), .Reset(Reset), .Valid(Valid), .Gray(Gray), .Clear(Clear),
    .Bin(bin_b), .Locked(locked_b), .Error(error_b), .WrapCount(wrap_b)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [2:0] to_gray(input int b);
    return 3'((b % 8) ^ ((b % 8) >> 1));
  endfunction

  // Decode by searching the code table rather than XOR-folding bits.
  function automatic int from_gray(input logic [2:0] g);
    for (int b = 0; b < 8; b++)
      if (to_gray(b) == g) return b;
    return -1;
  endfunction

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".bin"},      32'(bin_a),    32'(m_bin));
    check({tag, ".locked"},   32'(locked_a), 32'(m_locked));
    check({tag, ".error"},    32'(error_a),  32'(m_error));
    check({tag, ".wrap8"},    32'(wrap_a),   32'(sat(m_wraps, 255)));
    check({tag, ".w2.bin"},   32'(bin_b),    32'(m_bin));
    check({tag, ".w2.state"}, 32'({locked_b, error_b}), 32'({m_locked, m_error}));
    check({tag, ".wrap2"},    32'(wrap_b),   32'(sat(m_wraps, 3)));
  endtask

  task automatic model_reset();
    m_bin = 0; m_locked = 0; m_error = 0; m_wraps = 0;
  endtask

  task automatic model_step(input bit v, input logic [2:0] g, input bit c);
    int d;
    d = from_gray(g);
    if (!v) return;
    if (m_error) begin
      if (c) m_error = 0;
    end else if (!m_locked) begin
      m_bin = d; m_locked = 1;
    end else if (d == m_bin) begin
      // hold
    end else if (d == (m_bin + 1) % 8) begin
      if (m_bin == 7) m_wraps++;
      m_bin = d;
    end else begin
      m_locked = 0; m_error = 1;
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked at
  // the same offset after the following edge.
  task automatic step(input string tag, input bit v, input logic [2:0] g, input bit c);
    Valid = v; Gray = g; Clear = c;
    @(posedge Clk);
    model_step(v, g, c);
    #1;
    check_all(tag);
  endtask

  // Assert Reset between edges and check the outputs clear before any edge.
  task automatic async_reset(input string tag);
    #2 Reset = 1'b1;
    #1;
    model_reset();
    check_all({tag, ".async"});
    @(posedge Clk);
    #1 Reset = 1'b0;
    Valid = 1'b0;
  endtask

  task automatic idle_burst(input string tag);
    for (int i = 0; i < 10; i++)
      step(tag, 1'b0, 3'($urandom_range(0, 7)), bit'(i % 2));
  endtask

  task automatic full_cycles(input string tag, input int n);
    for (int i = 1; i <= 8 * n; i++)
      step(tag, 1'b1, to_gray(i), 1'b0);
  endtask

  initial begin
    Reset = 1'b1; Valid = 1'b0; Gray = 3'b000; Clear = 1'b0;
    model_reset();
    #3;
    check_all("reset");
    @(posedge Clk);
    #1 Reset = 1'b0;

    // Count up through one full Gray sequence back to 000.
    step("seq.lock", 1'b1, 3'b000, 1'b0);
    full_cycles("seq", 1);
    check("seq.one_wrap", 32'(wrap_a), 32'd1);
    idle_burst("idle.track");

    // Skip from 1 to 3, with a repeated sample first.
    async_reset("skip");
    step("skip.lock", 1'b1, 3'b001, 1'b0);
    step("skip.hold", 1'b1, 3'b001, 1'b0);
    step("skip.jump", 1'b1, 3'b010, 1'b0);
    idle_burst("idle.fault");
    step("skip.clear", 1'b1, 3'b000, 1'b1);
    idle_burst("idle.unlock");

    // Backward step from 2 to 1, then samples ignored until Clear.
    step("back.lock", 1'b1, 3'b000, 1'b0);
    step("back.s1",   1'b1, 3'b001, 1'b0);
    step("back.s2",   1'b1, 3'b011, 1'b0);
    step("back.rev",  1'b1, 3'b001, 1'b0);
    step("back.ign0", 1'b1, 3'b010, 1'b0);
    step("back.ign1", 1'b1, 3'b110, 1'b0);
    step("back.clr",  1'b1, 3'b111, 1'b1);
    step("back.relock", 1'b1, 3'b101, 1'b1);

    // Five full cycles: the 2-bit counter saturates at 3.
    async_reset("sat");
    step("sat.lock", 1'b1, 3'b000, 1'b0);
    full_cycles("sat", 5);
    check("sat.w2_saturated", 32'(wrap_b), 32'd3);

    // Reset in FAULT with four wraps recorded, then relock at 4.
    async_reset("fr");
    step("fr.lock", 1'b1, 3'b000, 1'b0);
    full_cycles("fr", 4);
    step("fr.fault", 1'b1, to_gray(2), 1'b0);
    async_reset("fr");
    step("fr.relock", 1'b1, 3'b110, 1'b0);

    // Randomised traffic biased towards legal steps.
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [2:0] g;
      r = $urandom_range(0, 9);
      if (r < 6)      g = to_gray(m_bin + 1);
      else if (r < 8) g = to_gray(m_bin);
      else            g = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) async_reset("rnd");
      else step("rnd", bit'($urandom_range(0, 4) != 0), g, bit'($urandom_range(0, 5) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_gray_monitor
